l2_cache_nway: RTL

- Parametrised N-way set-associative, write-back, write-allocate L2 cache.
- Holds both the datapath and the controlling FSM.
- Sits between the L1 caches/arbiter (upstream, full 128-bit line transfers) and physical memory (downstream).
- Generalises the 2-way L2 with:
  - any power-of-two way count;
  - tree pseudo-LRU replacement;
  - invalid-way-first victim selection;
  - correct tag/index split for any set count;
  - an explicit writeback/fill sequencer.

---
 rtl/l2_cache_nway_pkg.sv | 15 +
 rtl/l2_cache_nway_if.sv | 18 +
 rtl/l2_cache_nway_plru_tree.sv | 41 ++++
 rtl/l2_cache_nway.sv | 135 +++++++++++++
 4 files changed

// File: rtl/l2_cache_nway_pkg.sv
// Shared types and constants for the N-way set-associative L2 cache.
package l2_cache_pkg;

    localparam int LINE_OFFSET_BITS = 4;
    localparam int L2_LINE_WIDTH    = 128;

    typedef logic [L2_LINE_WIDTH-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } l2_state_t;

endpackage

// File: rtl/l2_cache_nway_if.sv
// Full-line request/response bus, used both upstream (cache as slave) and
// downstream to physical memory (cache as master).
interface l2_cache_nway_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [LINE_WIDTH-1:0] wdata;
    logic [LINE_WIDTH-1:0] rdata;
    logic                  resp;

    modport master (output read, output write, output address, output wdata,
                    input  rdata, input resp);
    modport slave  (input  read, input write, input address, input wdata,
                    output rdata, output resp);
endinterface

// File: rtl/l2_cache_nway_plru_tree.sv
// Combinational tree pseudo-LRU: update for an accessed way and victim walk.
// Node n has children 2n+1 (left, bit=0) and 2n+2 (right, bit=1).
module plru_tree #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         bits,
    input  logic [$clog2(WAYS)-1:0] access_way,
    output logic [WAYS-2:0]         bits_next,
    output logic [$clog2(WAYS)-1:0] victim_way
);
    localparam int WAY_W = $clog2(WAYS);

    // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
    always_comb begin
        int node;
        bits_next = bits;
        node      = 0;
        for (int lvl = WAY_W - 1; lvl >= 0; lvl--) begin
            for (int n = 0; n < WAYS - 1; n++) begin
                if (n == node) bits_next[n] = ~access_way[lvl];
            end
            node = 2 * node + 1 + int'(access_way[lvl]);
        end
    end

    always_comb begin
        int   node;
        logic dir;
        victim_way = '0;
        node       = 0;
        for (int lvl = WAY_W - 1; lvl >= 0; lvl--) begin
            dir = 1'b0;
            for (int n = 0; n < WAYS - 1; n++) begin
                if (n == node) dir = bits[n];
            end
            victim_way[lvl] = dir;
            node = 2 * node + 1 + int'(dir);
        end
    end

endmodule

// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back, write-allocate L2 cache with tree PLRU
// replacement and a WRITEBACK/FILL miss sequencer.
module l2_cache_nway
    import l2_cache_pkg::*;
#(
    parameter int WAYS       = 4,
    parameter int SETS       = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic          clk,
    input  logic          reset,
    l2_cache_nway_if.slave  mem,
    l2_cache_nway_if.master pmem
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - LINE_OFFSET_BITS - IDX_W;
    localparam int WAY_W = $clog2(WAYS);

    logic [LINE_WIDTH-1:0] data_q  [SETS][WAYS];
    logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       dirty_q [SETS];
    logic [WAYS-2:0]       plru_q  [SETS];

    l2_state_t        state_q, state_d;
    logic [WAY_W-1:0] victim_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             req, hit, hit_commit, fill_done;
    logic [WAYS-1:0]  match;
    logic [WAY_W-1:0] hit_way, miss_victim, plru_victim;
    logic [WAYS-2:0]  plru_next;

    assign idx = mem.address[LINE_OFFSET_BITS +: IDX_W];
    assign tag = mem.address[ADDR_WIDTH-1 -: TAG_W];
    assign req = mem.read | mem.write;

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
            if (match[w]) hit_way = WAY_W'(w);
        end
    end
    assign hit = |match;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits       (plru_q[idx]),
        .access_way (hit_way),
        .bits_next  (plru_next),
        .victim_way (plru_victim)
    );

    // Lowest-numbered invalid way wins; PLRU only decides among a full set.
    always_comb begin
        miss_victim = plru_victim;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) miss_victim = WAY_W'(w);
        end
    end

    assign hit_commit = (state_q == IDLE) && req && hit;
    assign fill_done  = (state_q == FILL) && pmem.resp;
    assign mem.rdata  = data_q[idx][hit_way];

    always_comb begin
        state_d      = state_q;
        mem.resp     = 1'b0;
        pmem.read    = 1'b0;
        pmem.write   = 1'b0;
        pmem.address = '0;
        pmem.wdata   = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit)
                        mem.resp = 1'b1;
                    else if (valid_q[idx][miss_victim] && dirty_q[idx][miss_victim])
                        state_d = WRITEBACK;
                    else
                        state_d = FILL;
                end
            end
            WRITEBACK: begin
                pmem.write   = 1'b1;
                pmem.address = {tag_q[idx][victim_q], idx, {LINE_OFFSET_BITS{1'b0}}};
                pmem.wdata   = data_q[idx][victim_q];
                if (pmem.resp) state_d = FILL;
            end
            FILL: begin
                pmem.read    = 1'b1;
                pmem.address = {tag, idx, {LINE_OFFSET_BITS{1'b0}}};
                if (pmem.resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req && !hit) victim_q <= miss_victim;
            if (hit_commit) begin
                plru_q[idx] <= plru_next;
                if (mem.write) dirty_q[idx][hit_way] <= 1'b1;
            end
            if (fill_done) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
        end
    end

    // NOTE: data and tag arrays are deliberately unreset; valid qualifies them, which keeps them RAM-mappable.
    always_ff @(posedge clk) begin
        if (hit_commit && mem.write) begin
            data_q[idx][hit_way] <= mem.wdata;
        end else if (fill_done) begin
            data_q[idx][victim_q] <= pmem.rdata;
            tag_q[idx][victim_q]  <= tag;
        end
    end

endmodule
